// File: rtl/reg_bank_pkg.sv
// Shared definitions for the 32x32 register bank, used by both the write port and the read muxes.
package reg_bank_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG0_ADDR = '0;

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } state_t;

endpackage

// File: rtl/reg_bank_write_port_decoder5to32.sv
// One-hot address decoder with enable; the output is all zeros when en is low.
module decoder5to32
    import reg_bank_pkg::*;
(
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign onehot[gi] = en && (addr == ADDR_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/reg_bank_write_port.sv
// Write side of the register bank: one-hot decoded external writes, register 0 tied
// to zero, and a sequential init engine that fills registers 1..NUM_REGS-1.
module reg_bank_write_port
    import reg_bank_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VAL = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ready,
    input  logic                       init_req,
    output logic                       init_busy,
    output logic [NUM_REGS*DATA_W-1:0] reg_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              accept;
    logic [NUM_REGS-1:0] ext_we;
    logic [NUM_REGS-1:0] init_we;
    logic              unused_we0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= FIRST_ADDR;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The counter reloads instead of incrementing past the last register, so it never reaches 0.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (init_req) begin
                    state_next = INIT;
                    cnt_next   = FIRST_ADDR;
                end
            end
            INIT: begin
                if (cnt_reg == LAST_ADDR) begin
                    state_next = IDLE;
                    cnt_next   = FIRST_ADDR;
                end else begin
                    cnt_next = cnt_reg + FIRST_ADDR;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = FIRST_ADDR;
            end
        endcase
    end

    assign wr_ready  = (state_reg == IDLE);
    assign init_busy = (state_reg == INIT);
    assign accept    = wr_en && wr_ready;

    decoder5to32 u_ext_dec (
        .en     (accept),
        .addr   (wr_addr),
        .onehot (ext_we)
    );

    decoder5to32 u_init_dec (
        .en     (init_busy),
        .addr   (cnt_reg),
        .onehot (init_we)
    );

    assign unused_we0 = ext_we[REG0_ADDR] | init_we[REG0_ADDR];

    // External and init load enables are mutually exclusive since writes only accept in IDLE.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == int'(REG0_ADDR)) begin : g_zero
                assign reg_out[DATA_W*gi +: DATA_W] = '0;
            end else begin : g_store
                logic [DATA_W-1:0] q_reg;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        q_reg <= '0;
                    end else if (init_we[gi]) begin
                        q_reg <= INIT_VAL;
                    end else if (ext_we[gi]) begin
                        q_reg <= wr_data;
                    end
                end
                assign reg_out[DATA_W*gi +: DATA_W] = q_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_reg_bank_write_port.sv
// Directed bench for reg_bank_write_port with a cycle model feeding a scoreboard queue.
module tb_reg_bank_write_port;
    import reg_bank_pkg::*;

    localparam logic [DATA_W-1:0] IV = 32'hA5A5_A5A5;
    localparam int W = NUM_REGS * DATA_W;

    logic                clk = 1'b0;
    logic                rst, wr_en, init_req;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_ready, init_busy;
    logic [W-1:0]        reg_out;

    always #5 clk = ~clk;

    reg_bank_write_port #(.INIT_VAL(IV)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .init_req  (init_req),
        .init_busy (init_busy),
        .reg_out   (reg_out)
    );

    typedef struct {
        logic         ready;
        logic         busy;
        logic [W-1:0] image;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] m [NUM_REGS];
    logic              m_busy = 1'b0;
    int                m_cnt = 1;
    int                n_pass = 0;
    int                n_total = 0;
    int                busy_cycles;
    int                guard;

    function automatic logic [W-1:0] img();
        logic [W-1:0] r;
        for (int i = 0; i < NUM_REGS; i++) r[i*DATA_W +: DATA_W] = m[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_img(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        int idx = 0;
        for (int i = NUM_REGS - 1; i >= 0; i--)
            if (obs[i*DATA_W +: DATA_W] !== exp[i*DATA_W +: DATA_W]) idx = i;
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s reg%0d: got %h expected %h", tag, idx,
                   obs[idx*DATA_W +: DATA_W], exp[idx*DATA_W +: DATA_W]);
        end
    endtask

    // Advance the model on the current inputs, push its prediction, clock, then pop and compare.
    task automatic step();
        exp_t e;
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) m[i] = '0;
            m_busy = 1'b0;
            m_cnt  = 1;
        end else begin
            if (wr_en && !m_busy && wr_addr != 0) m[wr_addr] = wr_data;
            if (!m_busy) begin
                if (init_req) begin
                    m_busy = 1'b1;
                    m_cnt  = 1;
                end
            end else begin
                m[m_cnt] = IV;
                if (m_cnt == NUM_REGS - 1) begin
                    m_busy = 1'b0;
                    m_cnt  = 1;
                end else begin
                    m_cnt++;
                end
            end
        end
        e.ready = !m_busy;
        e.busy  = m_busy;
        e.image = img();
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("wr_ready", {31'b0, wr_ready}, {31'b0, e.ready});
        chk("init_busy", {31'b0, init_busy}, {31'b0, e.busy});
        chk_img("reg_out", reg_out, e.image);
    endtask

    function automatic logic [DATA_W-1:0] slice(input int n);
        return reg_out[n*DATA_W +: DATA_W];
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b0; init_req = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < NUM_REGS; i++) m[i] = '0;
        step();
        step();
        rst = 1'b0;
        chk_img("reset_image", reg_out, '0);
        chk("reset_ready", {31'b0, wr_ready}, 32'd1);
        chk("reset_busy", {31'b0, init_busy}, 32'd0);
        step();

        // Basic write
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        step();
        wr_en = 1'b0;
        chk("reg5_write", slice(5), 32'hDEAD_BEEF);
        chk("reg4_untouched", slice(4), 32'h0);

        // Address-0 write is discarded
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        step();
        wr_en = 1'b0;
        chk("reg0_zero", slice(0), 32'h0);
        chk("reg5_kept", slice(5), 32'hDEAD_BEEF);

        // Back-to-back writes to one address
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1111_1111;
        step();
        wr_data = 32'h2222_2222;
        step();
        wr_en = 1'b0;
        chk("reg3_last", slice(3), 32'h2222_2222);

        // Init fill, with a stray init_req mid-fill that must be ignored
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        busy_cycles = (init_busy === 1'b1) ? 1 : 0;
        guard = 0;
        while (init_busy === 1'b1 && guard < 40) begin
            init_req = (guard == 5);
            step();
            init_req = 1'b0;
            if (init_busy === 1'b1) busy_cycles++;
            guard++;
        end
        chk("fill_busy_len", busy_cycles, 32'd31);
        chk("fill_ready", {31'b0, wr_ready}, 32'd1);
        chk("fill_reg0", slice(0), 32'h0);
        for (int i = 1; i < NUM_REGS; i++) chk($sformatf("fill_reg%0d", i), slice(i), IV);

        // Stall during init: write held through the fill, coinciding with init_req
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678; init_req = 1'b1;
        step();
        init_req = 1'b0;
        busy_cycles = (init_busy === 1'b1) ? 1 : 0;
        guard = 0;
        while (wr_ready !== 1'b1 && guard < 40) begin
            step();
            if (init_busy === 1'b1) busy_cycles++;
            guard++;
        end
        chk("stall_busy_len", busy_cycles, 32'd31);
        chk("stall_reg7_dropped", slice(7), IV);
        step();
        wr_en = 1'b0;
        chk("stall_reg7_accepted", slice(7), 32'h1234_5678);
        step();

        // Reset mid-init, then a clean full fill
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", {31'b0, init_busy}, 32'd0);
        chk("abort_ready", {31'b0, wr_ready}, 32'd1);
        chk_img("abort_image", reg_out, '0);
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        busy_cycles = (init_busy === 1'b1) ? 1 : 0;
        guard = 0;
        while (init_busy === 1'b1 && guard < 40) begin
            step();
            if (init_busy === 1'b1) busy_cycles++;
            guard++;
        end
        chk("refill_busy_len", busy_cycles, 32'd31);
        chk("refill_reg31", slice(31), IV);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_bank_write_port.md
Name: reg_bank_write_port

Overview:
Write side of the 32x32 register bank. It decodes a 5-bit write address into a one-hot enable and stores write-back data into 32 registers, with register 0 hardwired to zero. All 32 register values are exported as one flat bus that feeds the bank's 32-to-1 read muxes. A sequential init engine can fill registers 1..31 with a constant; during that fill the port stalls external writes through a ready handshake.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, write address width
NUM_REGS, 32, register count (2**ADDR_W)
INIT_VAL, 32'h0000_0000, value the init engine writes to registers 1..NUM_REGS-1

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  synchronous reset, active-high
WrEn  input  1  write request
WrAddr  input  ADDR_W  destination register index
WrData  input  DATA_W  write-back data
WrReady  output  1  high when an external write is accepted this cycle
InitReq  input  1  one-cycle pulse that starts the init fill
InitBusy  output  1  high while the init fill runs
RegOut  output  NUM_REGS*DATA_W  flat register image; register n occupies bits [DATA_W*n+DATA_W-1 : DATA_W*n]

Behaviour:
- Reset (Rst=1 at a Clk edge): all registers 0; state IDLE; init counter 1; WrReady=1; InitBusy=0. Rst has priority over every other input.
- States:
  - IDLE: WrReady=1, InitBusy=0.
  - INIT: WrReady=0, InitBusy=1.
  - WrReady and InitBusy are decoded from the registered state only, with no combinational path from the inputs.
- External write:
  - A write is accepted when WrEn=1 and WrReady=1.
  - The register at WrAddr takes WrData at that edge; the new value is on RegOut from the next cycle, so latency is 1.
  - WrEn while WrReady=0 is dropped. No queueing; the requester must hold the request until WrReady=1.
- Register 0: a write to address 0 is discarded. The RegOut slice for register 0 is constant 0 at all times, including during init.
- Init FSM:
  - IDLE -> INIT when InitReq=1. The counter loads 1.
  - In INIT, each cycle writes INIT_VAL to register[counter] and increments the counter.
  - After register NUM_REGS-1 is written, the FSM returns to IDLE and the counter reloads 1.
  - InitBusy is high for exactly NUM_REGS-1 (31) cycles. WrReady returns to 1 on the cycle after the last init write.
  - The counter is ADDR_W bits wide and never wraps through 0.
- Simultaneous events:
  - InitReq and an accepted WrEn on the same IDLE edge: the write is performed and INIT starts on that same edge. The written register is later overwritten by INIT_VAL (unless it is register 0).
  - InitReq during INIT is ignored; there is no restart and no extension of the fill.
  - Rst during INIT aborts the fill immediately: all registers 0, state IDLE.
- Stability: registers not addressed this cycle hold their value. The same address written on back-to-back cycles shows the last value.

Decomposition:
- Shared package reg_bank_pkg holds:
  - DATA_W, ADDR_W, NUM_REGS
  - the state encoding (IDLE=1'b0, INIT=1'b1)
  - the REG0_ADDR constant
  The read-mux side imports the same package.
- One sub-module: decoder5to32, a combinational ADDR_W-to-NUM_REGS one-hot decoder with an enable input. Its output is gated with the accept condition to drive the per-register load enables.
- The storage array, init counter and FSM live in the top level.

Test Plan:
- Reset check: assert Rst for 2 cycles, then release -> all RegOut slices 0, WrReady=1, InitBusy=0.
- Basic write: WrEn=1, WrAddr=5, WrData=32'hDEADBEEF for 1 cycle -> register 5 reads DEADBEEF on the next cycle; all other slices remain 0.
- Address-0 write: WrEn=1, WrAddr=0, WrData=32'hFFFFFFFF -> register 0 slice stays 0; no other register changes.
- Init fill: INIT_VAL=32'hA5A5A5A5, pulse InitReq -> InitBusy high for 31 cycles; registers 1..31 all equal A5A5A5A5; register 0 is 0; WrReady=1 on cycle 32.
- Stall during init: hold WrEn=1, WrAddr=7, WrData=32'h12345678 throughout the fill -> no write while InitBusy=1; the write is accepted on the first ready cycle, and register 7 reads 12345678 one cycle later.
- Reset mid-init: pulse InitReq, assert Rst at fill cycle 10 -> all registers 0, state IDLE, InitBusy=0 on the next cycle; a second InitReq pulse then runs a full 31-cycle fill.
